// File: rtl/trans_serializer_if.sv
// Handshake/bus bundle for trans_serializer: validated-word input side and byte-stream output side.
interface trans_serializer_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [127:0]  data_i;
  logic          valid_i;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic          byte_ready_i;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;

  modport master (
    output data_i, valid_i, byte_ready_i,
    input  byte_o, byte_valid_o, level_o, overflow_o, drop_cnt_o
  );

  modport slave (
    input  data_i, valid_i, byte_ready_i,
    output byte_o, byte_valid_o, level_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/trans_serializer.sv
// Buffers 128-bit validated transactions in a small FIFO and streams them out MSB byte first.
// Define TRANS_SER_CHECKSUM_EN to append an XOR checksum byte after the 16 data bytes.
module trans_serializer #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  trans_serializer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
`ifdef TRANS_SER_CHECKSUM_EN
  localparam logic [4:0] LAST = 5'd16;
`else
  localparam logic [4:0] LAST = 5'd15;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q, state_d;
  logic [127:0]   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  level;
  logic [127:0]   shreg_q, shreg_d;
  logic [4:0]     idx_q, idx_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;
`ifdef TRANS_SER_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  logic           empty, full, xfer, last_xfer, pop, push, drop;
  logic [7:0]     byte_cur;

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));

  // A pop needs registered non-empty state, so a push into an empty FIFO is never popped on the same edge.
  always_comb begin
    byte_cur = shreg_q[127:120];
`ifdef TRANS_SER_CHECKSUM_EN
    if (idx_q == LAST) byte_cur = csum_q;
`endif
    xfer      = (state_q == SEND) && bus.byte_ready_i;
    last_xfer = xfer && (idx_q == LAST);
    pop       = !empty && ((state_q == IDLE) || last_xfer);
    push      = bus.valid_i && (!full || pop);
    drop      = bus.valid_i && full && !pop;
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
`ifdef TRANS_SER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (xfer) begin
      shreg_d = {shreg_q[119:0], 8'h00};
      idx_d   = idx_q + 5'd1;
`ifdef TRANS_SER_CHECKSUM_EN
      csum_d  = csum_q ^ byte_cur;
`endif
    end

    // Loading on the last transfer keeps back-to-back words free of bubbles.
    if (pop) begin
      shreg_d = mem_q[rd_ptr_q[AW-1:0]];
      idx_d   = 5'd0;
      state_d = SEND;
`ifdef TRANS_SER_CHECKSUM_EN
      csum_d  = 8'h00;
`endif
    end else if (last_xfer) begin
      idx_d   = 5'd0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef TRANS_SER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef TRANS_SER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Storage is not reset; flushing the pointers is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_i;
  end

  assign bus.byte_o       = (state_q == SEND) ? byte_cur : 8'h00;
  assign bus.byte_valid_o = (state_q == SEND);
  assign bus.level_o      = level;
  assign bus.overflow_o   = overflow_q;
  assign bus.drop_cnt_o   = drop_cnt_q;
endmodule

// File: tb/tb_trans_serializer.sv
// Self-checking bench for trans_serializer: queue-based reference model plus directed and random traffic.
module tb_trans_serializer;
  localparam int DEPTH = 4;
`ifdef TRANS_SER_CHECKSUM_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam logic [127:0] W1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W2 = 128'hA55A_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] WC = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  trans_serializer_if #(.DEPTH(DEPTH)) bus();

  trans_serializer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: bytes still owed for the word in flight, plus whole words waiting.
  logic [7:0]   m_cur[$];
  logic [127:0] m_fifo[$];
  logic         m_ovf;
  int           m_drop;
  bit           m_xfer, m_pop, m_acc;
  logic [127:0] m_word;

  logic [7:0]   cap[$];
  int           peak;
  int           bubbles;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void loadWord(input logic [127:0] w);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    m_cur.delete();
    for (int k = 0; k < 16; k++) begin
      b = w[127-8*k -: 8];
      m_cur.push_back(b);
      x = x ^ b;
    end
`ifdef TRANS_SER_CHECKSUM_EN
    m_cur.push_back(x);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur.delete();
      m_fifo.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      m_xfer = (m_cur.size() > 0) && bus.byte_ready_i;
      m_pop  = (m_fifo.size() > 0) && ((m_cur.size() == 0) || (m_xfer && m_cur.size() == 1));
      m_acc  = bus.valid_i && ((m_fifo.size() < DEPTH) || m_pop);
      if (bus.valid_i && !m_acc) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (m_xfer) void'(m_cur.pop_front());
      if (m_pop) begin
        m_word = m_fifo.pop_front();
        loadWord(m_word);
      end
      if (m_acc) m_fifo.push_back(bus.data_i);
    end
  end

  // Compare process plus byte capture, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_byte_o",   {24'd0, bus.byte_o},     32'd0);
      checkOutput("rst_valid",    {31'd0, bus.byte_valid_o}, 32'd0);
      checkOutput("rst_level",    {29'd0, bus.level_o},    32'd0);
      checkOutput("rst_overflow", {31'd0, bus.overflow_o}, 32'd0);
      checkOutput("rst_drop",     {24'd0, bus.drop_cnt_o}, 32'd0);
    end else begin
      checkOutput("byte_valid", {31'd0, bus.byte_valid_o}, {31'd0, m_cur.size() > 0});
      if (m_cur.size() > 0) checkOutput("byte_o", {24'd0, bus.byte_o}, {24'd0, m_cur[0]});
      checkOutput("level",    {29'd0, bus.level_o},    32'(m_fifo.size()));
      checkOutput("overflow", {31'd0, bus.overflow_o}, {31'd0, m_ovf});
      checkOutput("drop_cnt", {24'd0, bus.drop_cnt_o}, 32'(m_drop));
      if (cap.size() > 0 && cap.size() < 3*NB && !bus.byte_valid_o) bubbles++;
      if (int'(bus.level_o) > peak) peak = int'(bus.level_o);
      if (bus.byte_valid_o && bus.byte_ready_i) cap.push_back(bus.byte_o);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] w);
    @(posedge clk); #1;
    bus.data_i  = w;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    bus.data_i       = '0;
    bus.valid_i      = 1'b0;
    bus.byte_ready_i = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;

    // Single word, ready high: latency and byte order.
    bus.byte_ready_i = 1'b1;
    cap.delete();
    @(posedge clk); #1;
    bus.data_i  = W1;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.byte_valid_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("t1_latency", 32'(lat), 32'd2);
    waitCycles(25);
    checkOutput("t1_count", 32'(cap.size()), 32'(NB));
    checkOutput("t1_byte0",  {24'd0, cap[0]},  32'h01);
    checkOutput("t1_byte7",  {24'd0, cap[7]},  32'hEF);
    checkOutput("t1_byte15", {24'd0, cap[15]}, 32'h10);
    checkOutput("t1_idle", {31'd0, bus.byte_valid_o}, 32'd0);

    // Same word with ready toggling 1-0-0-1.
    cap.delete();
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      bus.valid_i      = (c == 0);
      bus.data_i       = W1;
      bus.byte_ready_i = (c % 4 == 0) || (c % 4 == 3);
    end
    bus.byte_ready_i = 1'b1;
    waitCycles(5);
    checkOutput("t2_count", 32'(cap.size()), 32'(NB));
    checkOutput("t2_byte8",  {24'd0, cap[8]},  32'hFE);
    checkOutput("t2_byte15", {24'd0, cap[15]}, 32'h10);

    // Three words five cycles apart: contiguous stream, level peaks at 2.
    cap.delete();
    peak = 0;
    bubbles = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      bus.valid_i = (c == 0) || (c == 5) || (c == 10);
      bus.data_i  = {16{8'(c + 1)}};
    end
    checkOutput("t3_count", 32'(cap.size()), 32'(3*NB));
    checkOutput("t3_bubbles", 32'(bubbles), 32'd0);
    checkOutput("t3_peak", 32'(peak), 32'd2);

    // Overflow: ready low, six words, one dropped.
    bus.byte_ready_i = 1'b0;
    cap.delete();
    for (int k = 0; k < 6; k++) begin
      applyStimulus({16{8'(k + 1)}});
      waitCycles(4);
    end
    checkOutput("t4_overflow", {31'd0, bus.overflow_o}, 32'd1);
    checkOutput("t4_drop", {24'd0, bus.drop_cnt_o}, 32'd1);
    checkOutput("t4_level", {29'd0, bus.level_o}, 32'd4);
    bus.byte_ready_i = 1'b1;
    waitCycles(5*NB + 10);
    checkOutput("t4_count", 32'(cap.size()), 32'(5*NB));
    for (int k = 0; k < 5; k++) checkOutput("t4_order", {24'd0, cap[k*NB]}, 32'(k + 1));

    // Reset while byte 7 is on the output.
    cap.delete();
    applyStimulus(W1);
    n = 0;
    while (cap.size() < 7 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t5_reach_byte7", 32'(cap.size()), 32'd7);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_valid", {31'd0, bus.byte_valid_o}, 32'd0);
    checkOutput("t5_async_byte",  {24'd0, bus.byte_o}, 32'd0);
    checkOutput("t5_async_level", {29'd0, bus.level_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cap.delete();
    applyStimulus(W2);
    waitCycles(25);
    checkOutput("t5_count", 32'(cap.size()), 32'(NB));
    checkOutput("t5_byte0", {24'd0, cap[0]}, 32'hA5);
    checkOutput("t5_byte1", {24'd0, cap[1]}, 32'h5A);

    // Checksum word 0x01..0x10.
    cap.delete();
    applyStimulus(WC);
    waitCycles(25);
    checkOutput("t6_count", 32'(cap.size()), 32'(NB));
`ifdef TRANS_SER_CHECKSUM_EN
    checkOutput("t6_checksum", {24'd0, cap[16]}, 32'h10);
`else
    checkOutput("t6_last", {24'd0, cap[15]}, 32'h10);
`endif

    // Drop counter saturation.
    bus.byte_ready_i = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      bus.valid_i = 1'b1;
      bus.data_i  = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.valid_i = 1'b0;
    waitCycles(2);
    checkOutput("t7_drop_sat", {24'd0, bus.drop_cnt_o}, 32'd255);
    checkOutput("t7_overflow", {31'd0, bus.overflow_o}, 32'd1);
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.byte_ready_i = ($urandom_range(0, 3) != 0);
      bus.valid_i      = ($urandom_range(0, 5) == 0);
      bus.data_i       = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.valid_i      = 1'b0;
    bus.byte_ready_i = 1'b1;
    waitCycles(200);
    checkOutput("t8_drained_level", {29'd0, bus.level_o}, 32'd0);
    checkOutput("t8_drained_valid", {31'd0, bus.byte_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/trans_serializer.md
# trans_serializer

Output-side companion of the transaction validator: accepts the 128-bit validated-transaction word and its one-cycle valid pulse, buffers it in a small FIFO, and emits each word as a byte stream over a valid/ready handshake toward the host link (UART/USB bridge). The validator has no backpressure, so overflow is detected, counted and flagged instead of stalling upstream.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- data_i  input  128  transaction: [127:80] sender id, [79:32] receiver id, [31:10] amount, [9] block start, [8:0] passthrough
- valid_i  input  1  one-cycle pulse, data_i captured on this edge
- byte_o  output  8  current output byte
- byte_valid_o  output  1  byte_o holds a byte to transfer
- byte_ready_i  input  1  sink accepts byte; transfer = byte_valid_o && byte_ready_i at rising edge
- level_o  output  $clog2(DEPTH)+1  FIFO occupancy (excludes word in shift register)
- overflow_o  output  1  sticky, set on any dropped word
- drop_cnt_o  output  8  dropped-word count, saturates at 255

## Operation
- FIFO: registered pointers with one extra wrap bit; full = level==DEPTH, empty = level==0.
- Push on valid_i. If full and no pop on same edge: word dropped, overflow_o<=1, drop_cnt_o+1 (saturating at 255). If full with pop on same edge: push accepted, level unchanged.
- Serializer states: IDLE, SEND.
  - IDLE: byte_valid_o=0. If FIFO non-empty: pop head into 128-bit shift register, idx<=0, go SEND.
  - SEND: byte_valid_o=1, byte_o = shreg[127:120] (MSB byte first, byte k = data[127-8k -: 8]). On transfer: shift left 8, idx+1.
  - Last byte (idx==LAST) transferred: if FIFO non-empty pop next word same edge, stay SEND (no bubble); else go IDLE.
- LAST = 15 (16 bytes) or 16 with checksum (see Configuration).
- byte_o stable and byte_valid_o held while byte_ready_i low; no byte ever withdrawn or altered before transfer.
- A push into an empty FIFO while in IDLE and a pop are never on the same edge (pop requires non-empty registered state).
- Reset values: byte_o=0, byte_valid_o=0, level_o=0, overflow_o=0, drop_cnt_o=0, state IDLE, pointers 0, idx 0.
- Reset asserted mid-word: partial word discarded, FIFO flushed; after release stream restarts at byte 0 of the next pushed word.

## Timing
- valid_i at edge N (FIFO was empty, IDLE) → level_o=1 after N; pop at N+1; byte_valid_o=1 with byte 0 after N+1 (latency 2 cycles).
- With byte_ready_i held high: one byte per cycle, 16 (17) cycles per word, back-to-back words continuous.
- Sustained throughput 1 word per 16 (17) cycles; validator rate (≥5 cycles/word) can overflow under bursts — intended, reported via overflow_o.
- level_o, overflow_o, drop_cnt_o registered, update on the edge of the event.

## Configuration
- TRANS_SER_CHECKSUM_EN defined: after the 16 data bytes, append byte 16 = XOR of all 16 data bytes; LAST=16; checksum accumulated as bytes transfer, cleared on each word load.
- Not defined: exactly 16 bytes per word, no checksum logic present.

## Test plan
- Single word 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, ready high → byte_valid_o rises 2 cycles after valid_i, bytes 0x01,0x23,…,0x10 on 16 consecutive cycles, then IDLE.
- Same word, byte_ready_i toggled 1-0-0-1 pattern → identical byte sequence, byte_o stable during stalls, no duplicates or losses.
- Three valid_i pulses 5 cycles apart, ready high → 48 contiguous bytes, no bubble between words, level_o peaks at 2.
- DEPTH=4, ready low, 6 valid_i pulses → first word in shift reg, 4 in FIFO, 1 dropped: overflow_o=1, drop_cnt_o=1, level_o=4; after ready high the 5 kept words emerge in order.
- rst_n low at byte 7 of a word → outputs return to reset values asynchronously; next pushed word starts at byte 0.
- With TRANS_SER_CHECKSUM_EN, word of 16 bytes 0x01..0x10 → 17th byte 0x10 (XOR of 0x01..0x10); without macro, stream ends after 16 bytes.
